// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and helpers for the scanned BCD display.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Active-low {a,b,c,d,e,f,g,dp}; dp bit is left dark (1) here.
    localparam logic [7:0] GLYPH_0     = 8'h03;
    localparam logic [7:0] GLYPH_1     = 8'h9F;
    localparam logic [7:0] GLYPH_2     = 8'h25;
    localparam logic [7:0] GLYPH_3     = 8'h0D;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h49;
    localparam logic [7:0] GLYPH_6     = 8'h41;
    localparam logic [7:0] GLYPH_7     = 8'h1F;
    localparam logic [7:0] GLYPH_8     = 8'h01;
    localparam logic [7:0] GLYPH_9     = 8'h09;
    localparam logic [7:0] GLYPH_DASH  = 8'hFD;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    function automatic logic [7:0] seg7_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per cycle.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W    = 15,
    parameter int N_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [4*N_DIGITS-1:0]   bcd
);

    localparam int              BCD_W   = 4 * N_DIGITS;
    localparam int              CW      = $clog2(BIN_W);
    localparam logic [CW-1:0]   LAST    = CW'(BIN_W - 1);
    localparam logic [31:0]     MAX_VAL = 32'(pow10(N_DIGITS) - 1);

    conv_state_t        state_reg;
    logic [BIN_W-1:0]   shift_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_add3
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        shift_reg <= bin;
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        // Range check is done on the raw input; the BCD result truncates.
                        ovf_reg   <= (32'(bin) > MAX_VAL);
                        busy_reg  <= 1'b1;
                        state_reg <= CONV;
                    end
                end
                CONV: begin
                    bcd_reg   <= {bcd_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        done_reg  <= 1'b1;
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign ovf  = ovf_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/seg7_scan_bcd.sv
// Binary-in multiplexed 7-segment driver: double-dabble conversion plus digit scan.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module seg7_scan_bcd
    import seg7_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int STEP_HZ  = 300,
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIN_W-1:0]     bin,
    input  logic                 load,
    input  logic [N_DIGITS-1:0]  dp_sel,
    output logic                 busy,
    output logic                 ovf,
    output logic [7:0]           seg,
    output logic [N_DIGITS-1:0]  an
);

    localparam int              DIV_RAW  = CLK_HZ / STEP_HZ;
    localparam int              DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int              IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(N_DIGITS - 1);

    logic                   conv_busy;
    logic                   conv_done;
    logic                   conv_ovf;
    logic [4*N_DIGITS-1:0]  conv_bcd;

    logic [4*N_DIGITS-1:0]  disp_reg;
    logic                   ovf_reg;
    logic [PW-1:0]          pres_reg;
    logic [IW-1:0]          idx_reg;
    logic [7:0]             seg_reg;
    logic [N_DIGITS-1:0]    an_reg;

    logic                   tick;
    logic [N_DIGITS-1:0]    an_next;
    logic [N_DIGITS-1:0]    lzb_blank;
    logic [3:0]             cur_nib;
    logic [7:0]             seg_next;

    bin2bcd_seq #(
        .BIN_W    (BIN_W),
        .N_DIGITS (N_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .ovf   (conv_ovf),
        .bcd   (conv_bcd)
    );

    assign tick = (pres_reg == PRE_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_an
            assign an_next[gi] = (idx_reg != IW'(gi));
        end
    endgenerate

    // Walk down from the top digit; a digit blanks only while every digit above it is zero.
    always_comb begin
        lzb_blank = '0;
`ifdef SEG7_LZB_EN
        begin : lzb_scan
            logic run;
            run = 1'b1;
            for (int k = N_DIGITS - 1; k >= 1; k--) begin
                run          = run && (disp_reg[4*k +: 4] == 4'd0);
                lzb_blank[k] = run;
            end
        end
`endif
    end

    always_comb begin
        cur_nib = disp_reg[4*idx_reg +: 4];
        if (ovf_reg) begin
            seg_next = GLYPH_DASH;
        end else if (lzb_blank[idx_reg]) begin
            seg_next = GLYPH_BLANK;
        end else begin
            seg_next = seg7_glyph(cur_nib);
        end
        if (dp_sel[idx_reg]) begin
            seg_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_reg <= '0;
            ovf_reg  <= 1'b0;
            pres_reg <= '0;
            idx_reg  <= '0;
            seg_reg  <= GLYPH_BLANK;
            an_reg   <= '1;
        end else begin
            if (conv_done) begin
                disp_reg <= conv_bcd;
                ovf_reg  <= conv_ovf;
            end
            // seg and an load on the same edge so the glyph always matches its digit.
            if (tick) begin
                pres_reg <= '0;
                seg_reg  <= seg_next;
                an_reg   <= an_next;
                idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                pres_reg <= pres_reg + 1'b1;
            end
        end
    end

    assign busy = conv_busy;
    assign ovf  = ovf_reg;
    assign seg  = seg_reg;
    assign an   = an_reg;

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Scoreboard bench for seg7_scan_bcd: stimulus queues expected digit frames, monitor checks each scan step.
module tb_seg7_scan_bcd;

    localparam int CLK_HZ  = 1000;
    localparam int STEP_HZ = 250;
    localparam int N       = 4;
    localparam int BW      = 15;

`ifdef SEG7_LZB_EN
    localparam logic [7:0] ZH    = 8'hFF;
    localparam logic [7:0] ZH_DP = 8'hFE;
`else
    localparam logic [7:0] ZH    = 8'h03;
    localparam logic [7:0] ZH_DP = 8'h02;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [BW-1:0]  bin;
    logic           load;
    logic [N-1:0]   dp_sel;
    logic           busy;
    logic           ovf;
    logic [7:0]     seg;
    logic [N-1:0]   an;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    seg7_scan_bcd #(
        .CLK_HZ   (CLK_HZ),
        .STEP_HZ  (STEP_HZ),
        .N_DIGITS (N),
        .BIN_W    (BW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bin    (bin),
        .load   (load),
        .dp_sel (dp_sel),
        .busy   (busy),
        .ovf    (ovf),
        .seg    (seg),
        .an     (an)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        q.push_back({4'b1110, s0});
        q.push_back({4'b1101, s1});
        q.push_back({4'b1011, s2});
        q.push_back({4'b0111, s3});
    endtask

    task automatic do_load(input logic [BW-1:0] v);
        @(negedge clk);
        bin  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Align to the top digit so the next four scan steps are digits 0..3.
    task automatic sync_top;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            #1;
            if (an === 4'b0111) found = 1'b1;
        end
        if (!found) chk("sync_top", {28'd0, an}, 32'h7);
    endtask

    task automatic drain;
        for (int i = 0; i < 100 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        chk("queue_drained", q.size(), 0);
    endtask

    // Monitor: every scan step is checked against the queue head when one is pending.
    initial begin
        logic [3:0] prev;
        int         cyc;
        int         last;
        exp_t       e;
        prev = 4'b1111;
        cyc  = 0;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (an !== prev) begin
                if (an !== 4'b1111) begin
                    if (prev === 4'b0111 || prev === 4'b1110 ||
                        prev === 4'b1101 || prev === 4'b1011) begin
                        chk("tick_period", cyc - last, 4);
                        if (prev === 4'b0111) chk("index_wrap", {28'd0, an}, 32'he);
                    end
                    last = cyc;
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("scan_an", {28'd0, an}, {28'd0, e.an});
                        chk("scan_seg", {24'd0, seg}, {24'd0, e.seg});
                        $display("txn an=%b seg=%h  want an=%b seg=%h", an, seg, e.an, e.seg);
                    end
                end
                prev = an;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst    = 1'b0;
        load   = 1'b0;
        bin    = '0;
        dp_sel = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);

        // First tick after reset shows "0" on digit 0.
        push4(8'h03, ZH, ZH, ZH);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain();

        // 1234: busy for 16 cycles, digits 4,3,2,1.
        do_load(15'd1234);
        busy_len(n);
        chk("busy_cycles_1234", n, 16);
        chk("ovf_1234", {31'd0, ovf}, 0);
        sync_top();
        push4(8'h99, 8'h0D, 8'h25, 8'h9F);
        drain();

        // 10000 overflows a 4-digit display: dashes everywhere.
        do_load(15'd10000);
        busy_len(n);
        chk("busy_cycles_10000", n, 16);
        chk("ovf_10000", {31'd0, ovf}, 1);
        sync_top();
        push4(8'hFD, 8'hFD, 8'hFD, 8'hFD);
        drain();

        // Reset mid-conversion: outputs clear at once, display comes back as 0.
        do_load(15'd9999);
        repeat (4) @(negedge clk);
        chk("ovf_hold_conv", {31'd0, ovf}, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_seg", {24'd0, seg}, 32'hFF);
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_ovf", {31'd0, ovf}, 0);
        push4(8'h03, ZH, ZH, ZH);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain();

        // 9999 fits: no overflow, all nines.
        do_load(15'd9999);
        busy_len(n);
        chk("busy_cycles_9999", n, 16);
        chk("ovf_9999", {31'd0, ovf}, 0);
        sync_top();
        push4(8'h09, 8'h09, 8'h09, 8'h09);
        drain();

        // 42, then a load of 7 three cycles later that must be ignored.
        do_load(15'd42);
        @(negedge clk);
        @(negedge clk);
        bin  = 15'd7;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        busy_len(n);
        chk("busy_cycles_42_tail", n, 13);
        repeat (5) @(negedge clk);
        chk("no_requeue_busy", {31'd0, busy}, 0);
        sync_top();
        push4(8'h25, 8'h99, ZH, ZH);
        drain();

        // Value 0 with decimal point on digit 2.
        dp_sel = 4'b0100;
        do_load(15'd0);
        busy_len(n);
        chk("busy_cycles_0", n, 16);
        sync_top();
        push4(8'h03, ZH, ZH_DP, ZH);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
